// File: rtl/conv_config_rx_pkg.sv
// conv_config_pkg: shared constants for the conv configuration receiver.
// Holds the address map of the configuration stream, the field byte counts
// and the receiver FSM state type.
package conv_config_pkg;

  // Total number of words in one full configuration, commit word included
  localparam int unsigned CONFIG_WORDS = 35;
  // Address of the commit word; its data byte is ignored
  localparam int unsigned ADR_COMMIT   = 34;

  // Low-byte address of each field (fields are little-endian)
  localparam int unsigned ADR_WEIGHT_MAX_ADR    = 0;
  localparam int unsigned ADR_IFMAP_MAX_WADR    = 2;
  localparam int unsigned ADR_OFMAP_MAX_ADR     = 4;
  localparam int unsigned ADR_OX0               = 6;
  localparam int unsigned ADR_OY0               = 8;
  localparam int unsigned ADR_FX                = 10;
  localparam int unsigned ADR_FY                = 12;
  localparam int unsigned ADR_STRIDE            = 14;
  localparam int unsigned ADR_IX0               = 16;
  localparam int unsigned ADR_IY0               = 18;
  localparam int unsigned ADR_IC1               = 20;
  localparam int unsigned ADR_OC1               = 22;
  localparam int unsigned ADR_IC1_FY_FX_OY0_OX0 = 26;
  localparam int unsigned ADR_OY0_OX0           = 30;

  // Bytes occupied by the short and the wide fields in the address map
  localparam int unsigned FIELD_SHORT_BYTES = 2;
  localparam int unsigned FIELD_WIDE_BYTES  = 4;

  // Receiver FSM: LOAD accepts words, ACTIVE freezes the configuration
  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    ACTIVE = 1'b1
  } conf_state_e;

endpackage

// File: rtl/conv_config_rx_byte_field.sv
// config_byte_field: one configuration field assembled from NBYTES
// little-endian bytes starting at address BASE. Only the lowest OUT_W bits
// are kept; bytes (or parts of bytes) above OUT_W are dropped on write.
module config_byte_field #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NBYTES = 2,
  parameter int BASE   = 0,
  parameter int OUT_W  = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [OUT_W-1:0]  field
);

  // Bytes that carry at least one bit of the output; higher bytes are
  // accepted on the bus but have nowhere to land.
  localparam int CEIL_BYTES = (OUT_W + DATA_W - 1) / DATA_W;
  localparam int USED_BYTES = (NBYTES < CEIL_BYTES) ? NBYTES : CEIL_BYTES;

  logic [USED_BYTES-1:0] sel_s;
  logic [OUT_W-1:0]      value_r;

  // Decode which stored byte (if any) the current word addresses
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < USED_BYTES; i++) begin
      sel_s[i] = wr_en && (addr == ADDR_W'(BASE + i));
    end
  end

  // Bit-wise write so a partially used top byte is simply truncated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
    end else begin
      for (int b = 0; b < OUT_W; b++) begin
        if (sel_s[b / DATA_W]) begin
          value_r[b] <= data[b % DATA_W];
        end
      end
    end
  end

  assign field = value_r;

endmodule

// File: rtl/conv_config_rx.sv
// conv_config_rx: receiving end of the conv configuration stream.
// Collects {addr, byte} words into the layer-geometry registers while in
// LOAD, switches to ACTIVE on the commit word and holds everything stable
// until the layer reports done.
// Optional feature macro: CONFIG_ORDER_CHECK_EN -- enforces strictly
// increasing addresses 0..34 and adds the sticky config_err output.
module conv_config_rx
  import conv_config_pkg::*;
#(
  parameter int CONFIG_ADDR_WIDTH      = 8,
  parameter int CONFIG_DATA_WIDTH      = 8,
  parameter int WEIGHT_BANK_ADDR_WIDTH = 13,
  parameter int IFMAP_BANK_ADDR_WIDTH  = 12,
  parameter int OFMAP_BANK_ADDR_WIDTH  = 8,
  parameter int COUNTER_WIDTH          = 32
)(
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data,
  input  logic                                           config_vld,
  output logic                                           config_rdy,
  input  logic                                           layer_done,
  output logic                                           config_valid,
  output logic [WEIGHT_BANK_ADDR_WIDTH-1:0]              weight_max_adr,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               ifmap_max_wadr,
  output logic [OFMAP_BANK_ADDR_WIDTH-1:0]               ofmap_max_adr,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               OX0,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               OY0,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               FX,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               FY,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               STRIDE,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               IX0,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               IY0,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]               IC1,
  output logic [COUNTER_WIDTH-1:0]                       OC1,
  output logic [COUNTER_WIDTH-1:0]                       IC1_FY_FX_OY0_OX0,
  output logic [COUNTER_WIDTH-1:0]                       OY0_OX0
`ifdef CONFIG_ORDER_CHECK_EN
  ,
  output logic                                           config_err
`endif
);

  localparam int AW = CONFIG_ADDR_WIDTH;
  localparam int DW = CONFIG_DATA_WIDTH;

  logic [AW-1:0] addr_s;
  logic [DW-1:0] data_s;
  conf_state_e   state_r;
  conf_state_e   state_nxt_s;
  logic          rdy_r;
  logic          valid_r;
  logic          accept_s;
  logic          is_commit_s;
  logic          in_order_s;
  logic          wr_en_s;

  assign addr_s      = config_data[AW+DW-1:DW];
  assign data_s      = config_data[DW-1:0];
  // rdy_r is only ever 1 in LOAD, so it alone qualifies the handshake
  assign accept_s    = config_vld & rdy_r;
  assign is_commit_s = (addr_s == AW'(ADR_COMMIT));
  assign wr_en_s     = accept_s & in_order_s;

`ifdef CONFIG_ORDER_CHECK_EN
  logic [AW-1:0] exp_addr_r;
  logic          err_r;

  assign in_order_s = (addr_s == exp_addr_r);

  // Expected-address counter; held at 0 while ACTIVE so LOAD starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_addr_r <= '0;
    end else if (state_r == ACTIVE) begin
      exp_addr_r <= '0;
    end else if (accept_s && in_order_s) begin
      exp_addr_r <= exp_addr_r + AW'(1);
    end else begin
      exp_addr_r <= exp_addr_r;
    end
  end

  // Sticky sequence error: any consumed word at the wrong address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (accept_s && !in_order_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign config_err = err_r;
`else
  assign in_order_s = 1'b1;
`endif

  // Next-state logic: commit enters ACTIVE, layer_done returns to LOAD
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD: begin
        if (accept_s && is_commit_s && in_order_s) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      ACTIVE: begin
        if (layer_done) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      default: begin
        state_nxt_s = LOAD;
      end
    endcase
  end

  // State register plus registered handshake/status outputs; rdy stays low
  // during reset and rises on the first edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD;
      rdy_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rdy_r   <= (state_nxt_s == LOAD);
      valid_r <= (state_nxt_s == ACTIVE);
    end
  end

  assign config_rdy   = rdy_r;
  assign config_valid = valid_r;

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_WEIGHT_MAX_ADR), .OUT_W(WEIGHT_BANK_ADDR_WIDTH)) u_weight_max_adr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(weight_max_adr));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_IFMAP_MAX_WADR), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_ifmap_max_wadr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(ifmap_max_wadr));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_OFMAP_MAX_ADR), .OUT_W(OFMAP_BANK_ADDR_WIDTH)) u_ofmap_max_adr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(ofmap_max_adr));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_OX0), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_ox0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(OX0));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_OY0), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_oy0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(OY0));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_FX), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_fx (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(FX));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_FY), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_fy (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(FY));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_STRIDE), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_stride (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(STRIDE));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_IX0), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_ix0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(IX0));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_IY0), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_iy0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(IY0));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_SHORT_BYTES),
    .BASE(ADR_IC1), .OUT_W(IFMAP_BANK_ADDR_WIDTH)) u_ic1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(IC1));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_WIDE_BYTES),
    .BASE(ADR_OC1), .OUT_W(COUNTER_WIDTH)) u_oc1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(OC1));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_WIDE_BYTES),
    .BASE(ADR_IC1_FY_FX_OY0_OX0), .OUT_W(COUNTER_WIDTH)) u_ic1_fy_fx_oy0_ox0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(IC1_FY_FX_OY0_OX0));

  config_byte_field #(.ADDR_W(AW), .DATA_W(DW), .NBYTES(FIELD_WIDE_BYTES),
    .BASE(ADR_OY0_OX0), .OUT_W(COUNTER_WIDTH)) u_oy0_ox0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .addr(addr_s), .data(data_s),
    .field(OY0_OX0));

endmodule
